// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus: memory read request/response plus the decode slot.
// master = fetch unit (drives requests and the slot), slave = memory/decode side.
interface instruction_fetch_if;
    // Instruction-memory request channel
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;

    // Instruction-memory response channel
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    // Slot offered to decode
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_ready;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data,
        output inst_valid,
        output inst_data,
        output inst_pc,
        output inst_fault,
        input  inst_ready
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        input  inst_fault,
        output inst_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit with misaligned-PC fault path.
// Ports: clk, reset (sync, active-high), pc_in, pc_count_en, flush, bus (master).
module instruction_fetch #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc_in,
    output logic                  pc_count_en,
    input  logic                  flush,
    instruction_fetch_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state;
    logic        slot_valid;
    logic [31:0] slot_data;
    logic [31:0] slot_pc;
    logic        slot_fault;

    logic        misaligned;
    logic        req_fire;

    // A misaligned PC never reaches memory; it becomes a fault slot instead.
    assign misaligned = ALIGN_CHECK && (pc_in[1:0] != 2'b00);

    // Request and count-enable react to flush in the same cycle, so they are
    // decoded from the state rather than registered.
    always_comb begin
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = 32'd0;
        pc_count_en       = 1'b0;
        if (!reset) begin
            unique case (state)
                REQ: begin
                    bus.mem_req_valid = !flush && !misaligned;
                    bus.mem_req_addr  = pc_in;
                end
                HOLD: begin
                    pc_count_en = bus.inst_ready && !flush;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_fire = bus.mem_req_valid && bus.mem_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            slot_valid <= 1'b0;
            slot_data  <= 32'd0;
            slot_pc    <= 32'd0;
            slot_fault <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= REQ;
                end

                REQ: begin
                    if (flush) begin
                        state <= REQ;
                    end else if (misaligned) begin
                        slot_pc    <= pc_in;
                        slot_data  <= 32'd0;
                        slot_fault <= 1'b1;
                        slot_valid <= 1'b1;
                        state      <= HOLD;
                    end else if (req_fire) begin
                        slot_pc <= pc_in;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus.mem_resp_valid && !flush) begin
                        slot_data  <= bus.mem_resp_data;
                        slot_fault <= 1'b0;
                        slot_valid <= 1'b1;
                        state      <= HOLD;
                    end else if (bus.mem_resp_valid) begin
                        // Redirect coincides with the beat: drop it here.
                        state <= REQ;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    // The stale beat retires the old request; the PC was
                    // already redirected, so a coincident flush needs no wait.
                    if (bus.mem_resp_valid) begin
                        state <= REQ;
                    end
                end

                HOLD: begin
                    if (flush || bus.inst_ready) begin
                        slot_valid <= 1'b0;
                        state      <= REQ;
                    end
                end

                default: begin
                    state      <= IDLE;
                    slot_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inst_valid = slot_valid;
    assign bus.inst_data  = slot_data;
    assign bus.inst_pc    = slot_pc;
    assign bus.inst_fault = slot_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a random run
// against a transaction-level model of the fetch slot.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = 32'd0;
    logic        flush = 1'b0;
    logic        pce0;
    logic        pce1;

    instruction_fetch_if bus0();
    instruction_fetch_if bus1();

    assign bus1.mem_req_ready  = bus0.mem_req_ready;
    assign bus1.mem_resp_valid = bus0.mem_resp_valid;
    assign bus1.mem_resp_data  = bus0.mem_resp_data;
    assign bus1.inst_ready     = bus0.inst_ready;

    instruction_fetch #(.ALIGN_CHECK(1'b1)) u0 (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_count_en (pce0),
        .flush       (flush),
        .bus         (bus0.master)
    );

    instruction_fetch #(.ALIGN_CHECK(1'b0)) u1 (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_count_en (pce1),
        .flush       (flush),
        .bus         (bus1.master)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] pc, input logic rdy,
                          input logic rv, input logic [31:0] rd,
                          input logic ir, input logic fl);
        pc_in               = pc;
        bus0.mem_req_ready  = rdy;
        bus0.mem_resp_valid = rv;
        bus0.mem_resp_data  = rd;
        bus0.inst_ready     = ir;
        flush               = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its first request cycle after reset.
    task automatic do_reset(input logic [31:0] pc, input logic rdy);
        reset = 1'b1;
        set_in(pc, rdy, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Random-run environment and model state
    logic [31:0] epc;
    int unsigned due_q[$];
    logic [31:0] dat_q[$];
    int unsigned now;
    int unsigned last_due;
    bit          m_boot, m_slot, m_out, m_drop, m_fault;
    logic [31:0] m_pc, m_data, m_req_pc;

    initial begin : main
        int pulses;
        int hs;
        bit r, fl, rdy, ir, rv, exp_mrv, hs_s, pce_s;
        logic [31:0] rd, ftgt;

        // Reset release, zero-wait memory, decode always ready
        reset = 1'b1;
        set_in(32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst_inst_valid", bus0.inst_valid, 0);
        chk("rst_inst_data", bus0.inst_data, 0);
        chk("rst_inst_pc", bus0.inst_pc, 0);
        chk("rst_inst_fault", bus0.inst_fault, 0);
        chk("rst_req_valid", bus0.mem_req_valid, 0);
        chk("rst_req_addr", bus0.mem_req_addr, 0);
        chk("rst_pc_count_en", pce0, 0);

        reset = 1'b0;
        pulses = 0;
        set_in(32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("d1_c1_no_req", bus0.mem_req_valid, 0);
        pulses += pce0;
        tick();
        set_in(32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("d1_c2_req_valid", bus0.mem_req_valid, 1);
        chk("d1_c2_req_addr", bus0.mem_req_addr, 0);
        pulses += pce0;
        tick();
        set_in(32'd0, 1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b0);
        chk("d1_c3_no_req", bus0.mem_req_valid, 0);
        chk("d1_c3_no_inst", bus0.inst_valid, 0);
        pulses += pce0;
        tick();
        set_in(32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("d1_c4_inst_valid", bus0.inst_valid, 1);
        chk("d1_c4_inst_pc", bus0.inst_pc, 0);
        chk("d1_c4_inst_data", bus0.inst_data, 32'h13);
        chk("d1_c4_pce", pce0, 1);
        pulses += pce0;
        tick();
        set_in(32'd4, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("d1_c5_pce_low", pce0, 0);
        chk("d1_c5_req_valid", bus0.mem_req_valid, 1);
        chk("d1_c5_req_addr", bus0.mem_req_addr, 4);
        pulses += pce0;
        tick();
        set_in(32'd4, 1'b1, 1'b1, 32'h0000_0093, 1'b1, 1'b0);
        pulses += pce0;
        tick();
        set_in(32'd4, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("d1_c7_inst_pc", bus0.inst_pc, 4);
        chk("d1_c7_inst_data", bus0.inst_data, 32'h93);
        pulses += pce0;
        tick();
        set_in(32'd8, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        pulses += pce0;
        chk("d1_pulse_count", pulses, 2);

        // Memory stalls the request for three cycles
        do_reset(32'h100, 1'b0);
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            set_in(32'h100, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            chk("d2_stall_valid", bus0.mem_req_valid, 1);
            chk("d2_stall_addr", bus0.mem_req_addr, 32'h100);
            hs += int'(bus0.mem_req_valid & bus0.mem_req_ready);
            tick();
        end
        set_in(32'h100, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("d2_accept_addr", bus0.mem_req_addr, 32'h100);
        hs += int'(bus0.mem_req_valid & bus0.mem_req_ready);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(32'h100, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
            hs += int'(bus0.mem_req_valid & bus0.mem_req_ready);
            tick();
        end
        chk("d2_handshakes", hs, 1);

        // Flush while waiting; the late response must be dropped
        do_reset(32'h10, 1'b1);
        set_in(32'h10, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("d3_req_addr", bus0.mem_req_addr, 32'h10);
        tick();
        set_in(32'h10, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("d3_flush_no_req", bus0.mem_req_valid, 0);
        tick();
        set_in(32'h80, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("d3_drain_no_req", bus0.mem_req_valid, 0);
        tick();
        set_in(32'h80, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("d3_drain_no_inst", bus0.inst_valid, 0);
        tick();
        set_in(32'h80, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("d3_stale_dropped", bus0.inst_valid, 0);
        chk("d3_new_req", bus0.mem_req_valid, 1);
        chk("d3_new_addr", bus0.mem_req_addr, 32'h80);
        tick();

        // Flush and accept in the same HOLD cycle
        set_in(32'h80, 1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
        tick();
        set_in(32'h80, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("d4_hold_valid", bus0.inst_valid, 1);
        chk("d4_hold_data", bus0.inst_data, 32'h55);
        chk("d4_no_pce", pce0, 0);
        tick();
        set_in(32'h200, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("d4_slot_dropped", bus0.inst_valid, 0);
        chk("d4_back_to_req", bus0.mem_req_valid, 1);
        chk("d4_req_addr", bus0.mem_req_addr, 32'h200);

        // Misaligned PC with and without the alignment check
        do_reset(32'h102, 1'b1);
        set_in(32'h102, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("d5_chk_no_req", bus0.mem_req_valid, 0);
        chk("d5_nochk_req", bus1.mem_req_valid, 1);
        chk("d5_nochk_addr", bus1.mem_req_addr, 32'h102);
        tick();
        set_in(32'h102, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("d5_fault_valid", bus0.inst_valid, 1);
        chk("d5_fault_flag", bus0.inst_fault, 1);
        chk("d5_fault_pc", bus0.inst_pc, 32'h102);
        chk("d5_fault_data", bus0.inst_data, 0);
        chk("d5_fault_no_req", bus0.mem_req_valid, 0);
        chk("d5_nochk_no_fault", bus1.inst_valid, 0);

        // Reset during WAIT; response arrives after release
        do_reset(32'h40, 1'b1);
        set_in(32'h40, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        set_in(32'h40, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        set_in(32'h40, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
        chk("d6_idle_no_req", bus0.mem_req_valid, 0);
        chk("d6_idle_no_inst", bus0.inst_valid, 0);
        tick();
        set_in(32'h40, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("d6_fresh_req", bus0.mem_req_valid, 1);
        chk("d6_fresh_addr", bus0.mem_req_addr, 32'h40);
        chk("d6_resp_ignored", bus0.inst_valid, 0);
        tick();
        set_in(32'h40, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("d6_still_waiting", bus0.inst_valid, 0);

        // Random run against the transaction model
        epc = 32'h1000;
        now = 0;
        last_due = 0;
        reset = 1'b1;
        set_in(epc, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        m_boot = 1; m_slot = 0; m_out = 0; m_drop = 0; m_fault = 0;
        m_pc = 0; m_data = 0; m_req_pc = 0;

        for (int c = 0; c < 4000; c++) begin
            r   = ($urandom_range(0, 199) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            ir  = ($urandom_range(0, 9) < 6);
            ftgt = ($urandom_range(0, 1023) << 2);
            if ($urandom_range(0, 7) == 0)
                ftgt[1:0] = 2'($urandom_range(1, 3));
            rv = (due_q.size() > 0) && (due_q[0] <= now);
            rd = rv ? dat_q[0] : $urandom;
            if (rv) begin
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
            reset = r;
            set_in(epc, rdy, rv, rd, ir, fl);

            if (r) begin
                chk("rnd_rst_req", bus0.mem_req_valid, 0);
                chk("rnd_rst_pce", pce0, 0);
            end else begin
                exp_mrv = !m_boot && !m_slot && !m_out && !fl &&
                          (epc[1:0] == 2'b00);
                chk("rnd_req_valid", bus0.mem_req_valid, exp_mrv);
                if (exp_mrv)
                    chk("rnd_req_addr", bus0.mem_req_addr, epc);
                chk("rnd_inst_valid", bus0.inst_valid, m_slot);
                chk("rnd_pce", pce0, m_slot && ir && !fl);
                if (m_slot) begin
                    chk("rnd_inst_pc", bus0.inst_pc, m_pc);
                    chk("rnd_inst_data", bus0.inst_data, m_data);
                    chk("rnd_inst_fault", bus0.inst_fault, m_fault);
                end
            end
            hs_s  = !r && bus0.mem_req_valid && rdy;
            pce_s = pce0;

            @(posedge clk);

            if (r) begin
                m_boot = 1; m_slot = 0; m_out = 0; m_drop = 0;
            end else if (m_boot) begin
                m_boot = 0;
            end else if (m_slot) begin
                if (fl || ir) m_slot = 0;
            end else if (m_out) begin
                if (rv) begin
                    if (!m_drop && !fl) begin
                        m_slot = 1; m_pc = m_req_pc;
                        m_data = rd; m_fault = 0;
                    end
                    m_out = 0;
                    m_drop = 0;
                end else if (fl) begin
                    m_drop = 1;
                end
            end else if (!fl) begin
                if (epc[1:0] != 2'b00) begin
                    m_slot = 1; m_pc = epc; m_data = 0; m_fault = 1;
                end else if (rdy) begin
                    m_out = 1; m_req_pc = epc;
                end
            end

            if (hs_s) begin
                last_due = (now + $urandom_range(1, 3) > last_due) ?
                           now + $urandom_range(1, 3) : last_due + 1;
                due_q.push_back(last_due);
                dat_q.push_back(mem_word(epc));
            end
            if (fl)
                epc = ftgt;
            else if (pce_s)
                epc = epc + 32'd4;
            now++;
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
